// File: rtl/multicycle_sequencer_if.sv
// Control/status bundle between a multicycle sequencer and its datapath.
// The master drives the stage handshakes and redirect/halt requests; the slave reports state, PC and counters.
interface multicycle_sequencer_if #(
  parameter int XLEN    = 32,
  parameter int NSTAGES = 5
) ();
  localparam int SW = $clog2(NSTAGES + 1);

  logic               stage_done;
  logic               branch_taken;
  logic [XLEN-1:0]    branch_target;
  logic               halt_req;
  logic               resume;
  logic [SW-1:0]      state;
  logic [NSTAGES-1:0] stage_en;
  logic [XLEN-1:0]    pc;
  logic               wb_fire;
  logic               halted;
  logic [31:0]        retire_cnt;
  logic [31:0]        cycle_cnt;

  modport master (
    output stage_done, branch_taken, branch_target, halt_req, resume,
    input  state, stage_en, pc, wb_fire, halted, retire_cnt, cycle_cnt
  );

  modport slave (
    input  stage_done, branch_taken, branch_target, halt_req, resume,
    output state, stage_en, pc, wb_fire, halted, retire_cnt, cycle_cnt
  );
endinterface

// File: rtl/multicycle_sequencer.sv
// Multicycle instruction sequencer: steps one instruction through NSTAGES stages, then retires, branches or halts.
// Define MULTICYCLE_SEQUENCER_PERF_EN to build the retire/cycle performance counters.
module multicycle_sequencer #(
  parameter int                  XLEN      = 32,
  parameter int                  NSTAGES   = 5,
  parameter logic [NSTAGES-1:0]  WAIT_MASK = NSTAGES'(5'b01000),
  parameter logic [XLEN-1:0]     PC_RESET  = '0,
  parameter logic [XLEN-1:0]     PC_STEP   = XLEN'(4)
) (
  input logic                  clk,
  input logic                  rst,
  multicycle_sequencer_if.slave bus
);
  localparam int SW   = $clog2(NSTAGES + 1);
  localparam int PADW = 1 << SW;

  localparam logic [SW-1:0] S_FIRST = '0;
  localparam logic [SW-1:0] S_LAST  = SW'(NSTAGES - 1);
  localparam logic [SW-1:0] S_HALT  = SW'(NSTAGES);

  // Padded so it can be indexed by every state code, including HALT.
  localparam logic [PADW-1:0]    WAIT_PAD = PADW'(WAIT_MASK);
  localparam logic [NSTAGES-1:0] EN_ONE   = NSTAGES'(1);

  logic [SW-1:0]      state_r;
  logic [XLEN-1:0]    pc_r;
  logic               halted_r;
  logic [NSTAGES-1:0] stage_en_s;
  logic               adv_s;
  logic               wb_fire_s;

  // Stage strobe, advance condition and write-back fire; nothing fires while reset is held.
  always_comb begin
    stage_en_s = '0;
    adv_s      = 1'b0;
    wb_fire_s  = 1'b0;
    if (state_r != S_HALT) begin
      stage_en_s = EN_ONE << state_r;
      if (!WAIT_PAD[state_r] || bus.stage_done) begin
        adv_s = !rst;
      end else begin
        adv_s = 1'b0;
      end
      if (state_r == S_LAST) begin
        wb_fire_s = adv_s;
      end else begin
        wb_fire_s = 1'b0;
      end
    end else begin
      stage_en_s = '0;
      adv_s      = 1'b0;
      wb_fire_s  = 1'b0;
    end
  end

  // Stage sequencing, PC update at retirement, and HALT entry/exit.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= S_FIRST;
      pc_r     <= PC_RESET;
      halted_r <= 1'b0;
    end else if (state_r == S_HALT) begin
      if (bus.resume) begin
        state_r  <= S_FIRST;
        halted_r <= 1'b0;
      end else begin
        state_r  <= state_r;
        halted_r <= 1'b1;
      end
    end else if (wb_fire_s) begin
      // A taken branch still lands in pc when the same retirement also halts.
      pc_r <= bus.branch_taken ? bus.branch_target : pc_r + PC_STEP;
      if (bus.halt_req) begin
        state_r  <= S_HALT;
        halted_r <= 1'b1;
      end else begin
        state_r  <= S_FIRST;
        halted_r <= 1'b0;
      end
    end else if (adv_s) begin
      state_r <= state_r + SW'(1);
    end else begin
      state_r <= state_r;
    end
  end

  assign bus.state    = state_r;
  assign bus.pc       = pc_r;
  assign bus.halted   = halted_r;
  assign bus.stage_en = stage_en_s;
  assign bus.wb_fire  = wb_fire_s;

`ifdef MULTICYCLE_SEQUENCER_PERF_EN
  logic [31:0] retire_cnt_r;
  logic [31:0] cycle_cnt_r;

  // Retired-instruction and non-halted-cycle counters, both free-running with wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      retire_cnt_r <= 32'd0;
      cycle_cnt_r  <= 32'd0;
    end else begin
      retire_cnt_r <= wb_fire_s ? retire_cnt_r + 32'd1 : retire_cnt_r;
      cycle_cnt_r  <= (state_r != S_HALT) ? cycle_cnt_r + 32'd1 : cycle_cnt_r;
    end
  end

  assign bus.retire_cnt = retire_cnt_r;
  assign bus.cycle_cnt  = cycle_cnt_r;
`else
  assign bus.retire_cnt = 32'd0;
  assign bus.cycle_cnt  = 32'd0;
`endif

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Self-checking bench for multicycle_sequencer: an instruction-level reference model compared every cycle,
// plus directed scenarios with hand-computed expectations. Two instances differ only in PC_RESET.
module tb_multicycle_sequencer;
  localparam int         NST   = 5;
  localparam logic [4:0] WMASK = 5'b01000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  multicycle_sequencer_if #(.XLEN(32), .NSTAGES(NST)) sif ();
  multicycle_sequencer_if #(.XLEN(32), .NSTAGES(NST)) sif2 ();

  assign sif2.stage_done    = sif.stage_done;
  assign sif2.branch_taken  = sif.branch_taken;
  assign sif2.branch_target = sif.branch_target;
  assign sif2.halt_req      = sif.halt_req;
  assign sif2.resume        = sif.resume;

  multicycle_sequencer #(.XLEN(32), .NSTAGES(NST), .WAIT_MASK(WMASK),
                         .PC_RESET(32'h0000_0000), .PC_STEP(32'd4))
    dut (.clk(clk), .rst(rst), .bus(sif.slave));

  multicycle_sequencer #(.XLEN(32), .NSTAGES(NST), .WAIT_MASK(WMASK),
                         .PC_RESET(32'hFFFF_FFFC), .PC_STEP(32'd4))
    dut2 (.clk(clk), .rst(rst), .bus(sif2.slave));

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h @%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: current stage number (NST means halted), PCs of both instances, counters.
  int          m_stage = 0;
  logic [31:0] m_pc0, m_pc1, m_ret, m_cyc;
  bit          mvalid = 1'b0;

  function automatic bit m_adv();
    if (rst) return 1'b0;
    if (m_stage >= NST) return 1'b0;
    if (WMASK[m_stage[2:0]] == 1'b0) return 1'b1;
    return sif.stage_done;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_stage <= 0;
      m_pc0   <= 32'h0000_0000;
      m_pc1   <= 32'hFFFF_FFFC;
      m_ret   <= 32'd0;
      m_cyc   <= 32'd0;
      mvalid  <= 1'b1;
    end else if (m_stage == NST) begin
      if (sif.resume) m_stage <= 0;
    end else begin
      m_cyc <= m_cyc + 32'd1;
      if (m_adv()) begin
        if (m_stage == NST - 1) begin
          m_ret   <= m_ret + 32'd1;
          m_pc0   <= sif.branch_taken ? sif.branch_target : m_pc0 + 32'd4;
          m_pc1   <= sif.branch_taken ? sif.branch_target : m_pc1 + 32'd4;
          m_stage <= sif.halt_req ? NST : 0;
        end else begin
          m_stage <= m_stage + 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (mvalid) begin
      logic [4:0]  exp_en;
      logic        exp_wb;
      logic [31:0] exp_ret, exp_cyc;
      exp_en = (m_stage == NST) ? 5'd0 : (5'd1 << m_stage);
      exp_wb = m_adv() && (m_stage == NST - 1);
`ifdef MULTICYCLE_SEQUENCER_PERF_EN
      exp_ret = m_ret;
      exp_cyc = m_cyc;
`else
      exp_ret = 32'd0;
      exp_cyc = 32'd0;
`endif
      check("m_state", 64'(sif.state), 64'(m_stage));
      check("m_stage_en", 64'(sif.stage_en), 64'(exp_en));
      check("m_wb_fire", 64'(sif.wb_fire), 64'(exp_wb));
      check("m_pc", 64'(sif.pc), 64'(m_pc0));
      check("m_pc2", 64'(sif2.pc), 64'(m_pc1));
      check("m_halted", 64'(sif.halted), 64'(m_stage == NST));
      check("m_retire", 64'(sif.retire_cnt), 64'(exp_ret));
      check("m_cycle", 64'(sif.cycle_cnt), 64'(exp_cyc));
    end
  end

  // Drive one cycle of inputs, report stage_en/wb_fire mid-cycle, return just after the next edge.
  task automatic step(input logic d, input logic br, input logic [31:0] tgt, input logic hr,
                      input logic rsm, input logic rs, output logic [4:0] en, output logic wb);
    sif.stage_done    = d;
    sif.branch_taken  = br;
    sif.branch_target = tgt;
    sif.halt_req      = hr;
    sif.resume        = rsm;
    rst               = rs;
    @(negedge clk);
    en = sif.stage_en;
    wb = sif.wb_fire;
    @(posedge clk);
    #1;
  endtask

  task automatic run_instr(input int stalls, input logic br, input logic [31:0] tgt, input logic hr);
    logic [4:0] en;
    logic       wb;
    for (int s = 0; s < NST; s++) begin
      if (WMASK[s]) begin
        for (int k = 0; k < stalls; k++) step(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, en, wb);
      end
      if (s == NST - 1) step(1'b0, br, tgt, hr, 1'b0, 1'b0, en, wb);
      else              step(WMASK[s], 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, en, wb);
    end
  endtask

  initial begin
    logic [4:0] en;
    logic       wb;
    logic [4:0] exp_a [7];
    logic [6:0] a_done;
    logic [6:0] a_res;

    sif.stage_done = 1'b0; sif.branch_taken = 1'b0; sif.branch_target = 32'd0;
    sif.halt_req = 1'b0; sif.resume = 1'b0;
    step(1'b0, 1'b1, 32'h1234, 1'b1, 1'b1, 1'b1, en, wb);
    step(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b1, en, wb);
    check("rst_state", 64'(sif.state), 64'd0);
    check("rst_pc", 64'(sif.pc), 64'h0);
    check("rst_pc2", 64'(sif2.pc), 64'hFFFF_FFFC);
    check("rst_halted", 64'(sif.halted), 64'd0);
    check("rst_cnt", 64'({sif.retire_cnt, sif.cycle_cnt}), 64'd0);

    // One instruction, stage_done low for two cycles in stage 3, resume pulsed outside HALT.
    exp_a  = '{5'd1, 5'd2, 5'd4, 5'd8, 5'd8, 5'd8, 5'd16};
    a_done = 7'b0100000;
    a_res  = 7'b0000010;
    for (int i = 0; i < 7; i++) begin
      step(a_done[i], 1'b0, 32'd0, 1'b0, a_res[i], 1'b0, en, wb);
      check("A_stage_en", 64'(en), 64'(exp_a[i]));
      check("A_wb_fire", 64'(wb), 64'(i == 6));
    end
    check("A_pc", 64'(sif.pc), 64'h4);
    check("A_state", 64'(sif.state), 64'd0);
    check("D_pc_wrap", 64'(sif2.pc), 64'h0);

    // Branch at stage 2 ignored; branch at the last stage redirects.
    step(1'b0, 1'b0, 32'd0,     1'b0, 1'b0, 1'b0, en, wb);
    step(1'b0, 1'b0, 32'd0,     1'b0, 1'b0, 1'b0, en, wb);
    step(1'b0, 1'b1, 32'h200,   1'b1, 1'b0, 1'b0, en, wb);
    step(1'b1, 1'b1, 32'h300,   1'b0, 1'b0, 1'b0, en, wb);
    step(1'b0, 1'b1, 32'h100,   1'b0, 1'b0, 1'b0, en, wb);
    check("B_wb_fire", 64'(wb), 64'd1);
    check("B_pc", 64'(sif.pc), 64'h100);
    check("B_state", 64'(sif.state), 64'd0);
    check("B_pc2", 64'(sif2.pc), 64'h100);

    // Branch plus halt at retirement: HALT with the branch target held until resume.
    run_instr(0, 1'b1, 32'h40, 1'b1);
    check("C_halted", 64'(sif.halted), 64'd1);
    check("C_state", 64'(sif.state), 64'd5);
    check("C_stage_en", 64'(sif.stage_en), 64'd0);
    check("C_pc", 64'(sif.pc), 64'h40);
    step(1'b1, 1'b1, 32'h999, 1'b1, 1'b0, 1'b0, en, wb);
    step(1'b1, 1'b1, 32'h999, 1'b0, 1'b0, 1'b0, en, wb);
    check("C_hold_wb", 64'(wb), 64'd0);
    check("C_hold_pc", 64'(sif.pc), 64'h40);
    check("C_hold_state", 64'(sif.state), 64'd5);
    step(1'b0, 1'b0, 32'd0, 1'b0, 1'b1, 1'b0, en, wb);
    check("C_resume_state", 64'(sif.state), 64'd0);
    check("C_resume_halted", 64'(sif.halted), 64'd0);
    check("C_resume_pc", 64'(sif.pc), 64'h40);

    // Reset in the last stage suppresses the retirement that would otherwise fire.
    for (int s = 0; s < NST - 1; s++) step(WMASK[s], 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, en, wb);
    step(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b1, en, wb);
    check("R4_wb_fire", 64'(wb), 64'd0);
    check("R4_pc", 64'(sif.pc), 64'h0);

    // Reset while stalled in stage 3.
    for (int s = 0; s < 3; s++) step(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, en, wb);
    step(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, en, wb);
    step(1'b0, 1'b1, 32'h77, 1'b1, 1'b0, 1'b1, en, wb);
    check("F_wb_fire", 64'(wb), 64'd0);
    check("F_state", 64'(sif.state), 64'd0);
    check("F_pc", 64'(sif.pc), 64'h0);
    check("F_pc2", 64'(sif2.pc), 64'hFFFF_FFFC);
    check("F_cnt", 64'({sif.retire_cnt, sif.cycle_cnt}), 64'd0);
    check("F_stage_en", 64'(sif.stage_en), 64'd1);

    // Three one-stall instructions, the last halting, then two HALT cycles.
    run_instr(1, 1'b0, 32'd0, 1'b0);
    run_instr(1, 1'b0, 32'd0, 1'b0);
    run_instr(1, 1'b0, 32'd0, 1'b1);
    step(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, en, wb);
    step(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, en, wb);
    check("E_halted", 64'(sif.halted), 64'd1);
    check("E_pc", 64'(sif.pc), 64'hC);
`ifdef MULTICYCLE_SEQUENCER_PERF_EN
    check("E_retire", 64'(sif.retire_cnt), 64'd3);
    check("E_cycle", 64'(sif.cycle_cnt), 64'd18);
`else
    check("E_retire", 64'(sif.retire_cnt), 64'd0);
    check("E_cycle", 64'(sif.cycle_cnt), 64'd0);
`endif

    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
